async_req_arbiter: RTL and testbench

Takes N asynchronous request lines from board-level sources, such as fault comparators and gate-driver status pins, and synchronizes each one into the `clk` domain. A rising edge on a synchronized line latches a sticky pending bit. The block then grants one shared service resource, the housekeeping/ADC sequencer, to pending requesters in round-robin order. It holds each grant until the resource signals `done` or a timeout expires. The block sits between the pin-level inputs and the single shared service engine.

---
 rtl/async_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 47 ++++
 rtl/async_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_async_req_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/async_arb_pkg.sv
// async_arb_pkg: shared types and helpers for the async request arbiter.
//   state_t : arbiter FSM states
//   clog2   : elaboration-time ceil(log2) used for index/counter widths
//   N_MAX   : largest supported requester count
package async_arb_pkg;

  localparam int N_MAX = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // ceil(log2(v)); clog2(1) == 0, callers clamp to a minimum width of 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req     in  N   request vector
//   last_id in  IW  previously granted index; search starts just after it
//   onehot  out N   one-hot winner (0 when no request)
//   idx     out IW  winner index (0 when no request)
//   any     out 1   at least one request present
module rr_pick
  import async_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // The request vector is doubled so positions last_id+1 .. last_id+N are
  // contiguous; masking off everything at or below last_id and taking the
  // lowest remaining bit gives the rotating-priority winner without wrap logic.
  logic [2*N-1:0] dbl, msk, cand;

  always_comb begin
    dbl = {req, req};
    for (int j = 0; j < 2*N; j++) msk[j] = (j > int'(last_id));
    cand = dbl & msk;
  end

  always_comb begin
    int k;
    k      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (!any && cand[j]) begin
        any       = 1'b1;
        k         = (j >= N) ? (j - N) : j;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/async_req_arbiter.sv
// async_req_arbiter: synchronizes N asynchronous request lines, latches
// rising edges as sticky pending bits and grants one shared service resource
// round-robin, holding each grant until done or timeout.
//   clk       in  1   system clock
//   rst       in  1   asynchronous, active-high reset
//   async_req in  N   asynchronous request lines (rising edge = event)
//   enable    in  1   permits new grants
//   done      in  1   one-cycle pulse ending the current service
//   clr_ovr   in  1   clears all overrun flags
//   grant     out N   one-hot grant (registered)
//   grant_id  out IW  index of granted requester (registered)
//   busy      out 1   high while a grant is outstanding
//   pending   out N   latched events not yet granted
//   overrun   out N   sticky: event arrived while already pending
//   timeout   out 1   one-cycle pulse after a forced release
module async_req_arbiter
  import async_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 255,
  localparam int IW     = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  async_req,
  input  logic          enable,
  input  logic          done,
  input  logic          clr_ovr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic [N-1:0]  pending,
  output logic [N-1:0]  overrun,
  output logic          timeout
);

  // Counter is at least 1 bit so TIMEOUT == 0 still elaborates cleanly.
  localparam int CW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

  logic [N-1:0]  s1, s2, s3, evt;
  logic [N-1:0]  pick_oh, clr_mask;
  logic [IW-1:0] pick_idx, last_id;
  logic          pick_any;
  logic [CW-1:0] cnt;
  logic          tc, start, release_any, release_to;
  state_t        state, state_nxt;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer plus history flop. Resetting all three to 0 means
  // a line already high at reset release is seen as one rising edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= async_req;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign evt = s2 & ~s3;

  // ---------------------------------------------------------------------
  // Round-robin winner among pending requesters
  // ---------------------------------------------------------------------
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (pending),
    .last_id(last_id),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Terminal count only exists when the timeout is enabled.
  assign tc = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state. enable gates only the IDLE exit; BUSY ends on done or tc.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable && pick_any) state_nxt = S_BUSY;
      S_BUSY: if (done || tc)         state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs and strobes. done wins over tc, so a coincident pair is a
  // normal completion with no timeout pulse.
  always_comb begin
    start       = (state == S_IDLE) && enable && pick_any;
    release_any = (state == S_BUSY) && (done || tc);
    release_to  = (state == S_BUSY) && !done && tc;
    busy        = (state == S_BUSY);
  end

  // ---------------------------------------------------------------------
  // Pending / overrun. A new event on the requester being granted this edge
  // survives (set wins) and does not count as an overrun.
  // ---------------------------------------------------------------------
  assign clr_mask = start ? pick_oh : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | evt;
      overrun <= (clr_ovr ? '0 : overrun) | (evt & pending & ~clr_mask);
    end
  end

  // ---------------------------------------------------------------------
  // Grant, pointer, service counter and timeout pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= '0;
      grant_id <= '0;
      last_id  <= IW'(N - 1);
      cnt      <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= release_to;
      if (start) begin
        grant    <= pick_oh;
        grant_id <= pick_idx;
        last_id  <= pick_idx;
        cnt      <= '0;
      end else if (release_any) begin
        // grant_id keeps the last served index for software visibility.
        grant <= '0;
      end else if (busy && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_async_req_arbiter.sv
module tb_async_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] async_req;
  logic         enable, done, clr_ovr;
  logic [N-1:0] grant, pending, overrun;
  logic [1:0]   grant_id;
  logic         busy, timeout;

  int vectors = 0;
  int errs    = 0;

  async_req_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .async_req(async_req),
    .enable   (enable),
    .done     (done),
    .clr_ovr  (clr_ovr),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .pending  (pending),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; async_req = '0; enable = 1'b0; done = 1'b0; clr_ovr = 1'b0;
    cyc(2);
    chk("rst_grant",    32'(grant),    32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_pending",  32'(pending),  32'h0);
    chk("rst_overrun",  32'(overrun),  32'h0);
    chk("rst_timeout",  32'(timeout),  32'h0);

    // 1: single request on line 2
    rst = 1'b0; enable = 1'b1; async_req = 4'b0100;
    cyc(2);
    chk("t1_pend_early", 32'(pending), 32'h0);
    cyc(1);
    chk("t1_pend",       32'(pending), 32'h4);
    chk("t1_no_grant",   32'(grant),   32'h0);
    cyc(1);
    chk("t1_grant",      32'(grant),    32'h4);
    chk("t1_grant_id",   32'(grant_id), 32'h2);
    chk("t1_busy",       32'(busy),     32'h1);
    chk("t1_pend_clr",   32'(pending),  32'h0);
    async_req = 4'b0000;
    done = 1'b1; cyc(1); done = 1'b0;
    chk("t1_rel_grant",  32'(grant),    32'h0);
    chk("t1_rel_busy",   32'(busy),     32'h0);
    chk("t1_id_hold",    32'(grant_id), 32'h2);

    // 2: round robin from reset pointer
    rst = 1'b1; cyc(1); rst = 1'b0;
    async_req = 4'b1111;
    cyc(3);
    chk("t2_pend_all", 32'(pending), 32'hf);
    cyc(1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t2_grant%0d", i), 32'(grant),    32'(1 << i));
      chk($sformatf("t2_id%0d", i),    32'(grant_id), 32'(i));
      done = 1'b1; cyc(1); done = 1'b0;
      chk($sformatf("t2_gap%0d", i),   32'(grant),    32'h0);
      cyc(1);
    end
    chk("t2_pend_empty", 32'(pending), 32'h0);
    async_req = 4'b0000; cyc(3);
    async_req = 4'b1001; cyc(4);
    chk("t2b_grant0", 32'(grant), 32'h1);
    done = 1'b1; cyc(1); done = 1'b0;
    cyc(1);
    chk("t2b_grant3", 32'(grant),    32'h8);
    chk("t2b_id3",    32'(grant_id), 32'h3);
    done = 1'b1; cyc(1); done = 1'b0;

    // 3: timeout release after exactly TO cycles
    async_req = 4'b0000; cyc(3);
    async_req = 4'b0010; cyc(4);
    chk("t3_grant",     32'(grant),   32'h2);
    cyc(1);
    chk("t3_hold1",     32'(grant),   32'h2);
    cyc(3);
    chk("t3_hold4",     32'(grant),   32'h2);
    chk("t3_no_to_yet", 32'(timeout), 32'h0);
    cyc(1);
    chk("t3_released",  32'(grant),   32'h0);
    chk("t3_to_pulse",  32'(timeout), 32'h1);
    chk("t3_idle",      32'(busy),    32'h0);
    cyc(1);
    chk("t3_to_end",    32'(timeout), 32'h0);
    async_req = 4'b0000; cyc(3);
    async_req = 4'b0010; cyc(4);
    chk("t3b_grant",    32'(grant), 32'h2);
    cyc(4);
    done = 1'b1; cyc(1); done = 1'b0;
    chk("t3b_released", 32'(grant),   32'h0);
    chk("t3b_no_pulse", 32'(timeout), 32'h0);
    cyc(1);
    chk("t3b_no_pulse2", 32'(timeout), 32'h0);

    // 4: overrun with grants disabled
    enable = 1'b0; async_req = 4'b0000; cyc(3);
    async_req = 4'b0001; cyc(3);
    chk("t4_pend1",   32'(pending), 32'h1);
    chk("t4_ovr0",    32'(overrun), 32'h0);
    chk("t4_nogrant", 32'(grant),   32'h0);
    async_req = 4'b0000; cyc(3);
    async_req = 4'b0001; cyc(3);
    chk("t4_pend2",   32'(pending), 32'h1);
    chk("t4_ovr1",    32'(overrun), 32'h1);
    clr_ovr = 1'b1; cyc(1); clr_ovr = 1'b0;
    chk("t4_ovr_clr", 32'(overrun), 32'h0);
    enable = 1'b1; cyc(1);
    chk("t4_grant",   32'(grant),   32'h1);
    chk("t4_pend0",   32'(pending), 32'h0);
    done = 1'b1; cyc(1); done = 1'b0;
    cyc(2);
    chk("t4_one_grant", 32'(grant), 32'h0);
    chk("t4_idle",      32'(busy),  32'h0);

    // 5: new event on the same edge that grants requester 1
    enable = 1'b0; async_req = 4'b0011; cyc(3);
    chk("t5_pend", 32'(pending), 32'h2);
    async_req = 4'b0001; cyc(3);
    async_req = 4'b0011; cyc(2);
    enable = 1'b1; cyc(1);
    chk("t5_grant",     32'(grant),   32'h2);
    chk("t5_pend_kept", 32'(pending), 32'h2);
    chk("t5_no_ovr",    32'(overrun), 32'h0);
    done = 1'b1; cyc(1); done = 1'b0;
    chk("t5_gap", 32'(grant), 32'h0);
    cyc(1);
    chk("t5_regrant",  32'(grant),   32'h2);
    chk("t5_pend_end", 32'(pending), 32'h0);
    done = 1'b1; cyc(1); done = 1'b0;

    // 6: asynchronous reset during service
    async_req = 4'b0000; cyc(3);
    async_req = 4'b1100; cyc(4);
    chk("t6_grant2", 32'(grant),   32'h4);
    chk("t6_pend3",  32'(pending), 32'h8);
    async_req = 4'b1000;
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(grant),   32'h0);
    chk("t6_rst_busy",  32'(busy),    32'h0);
    chk("t6_rst_pend",  32'(pending), 32'h0);
    cyc(1); rst = 1'b0;
    cyc(4);
    chk("t6_grant3", 32'(grant),    32'h8);
    chk("t6_id3",    32'(grant_id), 32'h3);
    done = 1'b1; cyc(1); done = 1'b0;
    cyc(3);
    chk("t6_single",   32'(grant),   32'h0);
    chk("t6_pend_end", 32'(pending), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
